// File: rtl/ps2_pkg.sv
// Shared constants, frame-state enum and ps2_key field layout for the PS/2 keyboard decoder.
package ps2_pkg;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_ECHO   = 8'hEE;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    // Bytes following E1 that belong to the Pause sequence and carry no key event
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_W        = 11;
    localparam int KEY_TOG      = 10;
    localparam int KEY_PRESS    = 9;
    localparam int KEY_EXT      = 8;
    localparam int KEY_CODE_MSB = 7;
    localparam int KEY_CODE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    function automatic logic is_response(input logic [7:0] b);
        return (b == RSP_BAT) || (b == RSP_ACK) || (b == RSP_ECHO) || (b == RSP_RESEND);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line pair plus decoded key event outputs; slave is the decoder side, master the line/host side.
interface ps2_key_decoder_if;
    import ps2_pkg::*;

    logic             ps2_clk;
    logic             ps2_data;
    logic [KEY_W-1:0] ps2_key;
    logic             frame_err;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_err
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: synchronizers, clock glitch filter, 11-bit frame FSM with inactivity timeout.
//   state  | meaning
//   IDLE   | waiting for a start bit (sampled 0)
//   DATA   | shifting D0..D7, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity; byte or error strobe in this edge cycle
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT_CYC    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_TC = FW'(FILT_CYC - 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);

    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          fall;
    logic [TW-1:0] to_cnt;
    logic          to_expired;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    frame_state_t  state, state_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    // Any cycle where the synchronized clock agrees with the filtered one restarts the hold count
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
        end else if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_TC) begin
            filt_cnt <= '0;
            filt_clk <= clk_sync;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall       = filt_clk && !clk_sync && (filt_cnt == FILT_TC);
    assign to_expired = (to_cnt == '0);
    assign rx_byte    = shift;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !dat_sync) state_nxt = DATA;
            end
            DATA: begin
                if (fall) begin
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end else if (to_expired) begin
                    state_nxt = IDLE;
                end
            end
            PARITY: begin
                if (fall)            state_nxt = STOP;
                else if (to_expired) state_nxt = IDLE;
            end
            STOP: begin
                if (fall) begin
                    state_nxt = IDLE;
                    if (dat_sync && (^{shift, par_bit})) rx_valid = 1'b1;
                    else                                 rx_err   = 1'b1;
                end else if (to_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Timeout is a down-counter reloaded on every accepted falling edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt  <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else begin
            if (fall)                 to_cnt <= TO_LOAD;
            else if (!to_expired)     to_cnt <= to_cnt - 1'b1;
            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {dat_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_bit <= dat_sync;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: prefix (E0/F0), Pause skip and response filtering on top of ps2_rx_frame.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the held key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILT_CYC    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic                clk_sys,
    input logic                reset_n,
    ps2_key_decoder_if.slave   bus
);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_err;
    logic [KEY_W-1:0] key_q, key_nxt;
    logic             err_q;
    logic             ext, brk;
    logic [2:0]       skip_cnt;
    logic             code_byte;
    logic             emit;

    ps2_rx_frame #(
        .FILT_CYC    (FILT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       tm_valid;
    logic [8:0] tm_code;
    logic       tm_repeat;

    assign tm_repeat = tm_valid && (tm_code == {ext, rx_byte});

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tm_valid <= 1'b0;
            tm_code  <= '0;
        end else if (code_byte) begin
            if (brk) begin
                if (tm_repeat) tm_valid <= 1'b0;
            end else begin
                tm_valid <= 1'b1;
                tm_code  <= {ext, rx_byte};
            end
        end
    end
`endif

    always_comb begin
        code_byte = rx_valid && (skip_cnt == '0)
                    && (rx_byte != PFX_EXT) && (rx_byte != PFX_BRK) && (rx_byte != PFX_PAUSE)
                    && !(is_response(rx_byte) && !ext && !brk);
        emit = code_byte;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (code_byte && !brk && tm_repeat) emit = 1'b0;
`endif
        key_nxt = key_q;
        if (emit) begin
            key_nxt[KEY_TOG]                   = ~key_q[KEY_TOG];
            key_nxt[KEY_PRESS]                 = ~brk;
            key_nxt[KEY_EXT]                   = ext;
            key_nxt[KEY_CODE_MSB:KEY_CODE_LSB] = rx_byte;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_q    <= '0;
            err_q    <= 1'b0;
            ext      <= 1'b0;
            brk      <= 1'b0;
            skip_cnt <= '0;
        end else begin
            key_q <= key_nxt;
            err_q <= rx_err;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (skip_cnt != '0)           skip_cnt <= skip_cnt - 1'b1;
                else if (rx_byte == PFX_EXT)   ext      <= 1'b1;
                else if (rx_byte == PFX_BRK)   brk      <= 1'b1;
                else if (rx_byte == PFX_PAUSE) skip_cnt <= PAUSE_SKIP;
                else if (code_byte) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed key words and event counts.
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TO   = 400;
    localparam int HALF = 24;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int TM_EV = 2;
`else
    localparam int TM_EV = 4;
`endif

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   ev_cnt  = 0;
    int   err_cyc = 0;
    int   stray   = 0;
    logic [10:0] key_q = '0;
    logic        rst_q = 1'b0;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILT_CYC    (FILT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Event = toggle of ps2_key[10]; the other bits must never move on their own
    always @(negedge clk_sys) begin
        if (reset_n && rst_q) begin
            if (bus.ps2_key[10] !== key_q[10]) ev_cnt++;
            else if (bus.ps2_key[9:0] !== key_q[9:0]) stray++;
        end
        if (bus.frame_err === 1'b1) err_cyc++;
        key_q = bus.ps2_key;
        rst_q = reset_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        bus.ps2_data = b;
        cyc(HALF - 8);
        if (glitch) begin
            bus.ps2_clk = 1'b0;
            cyc(1);
            bus.ps2_clk = 1'b1;
            cyc(7);
        end else begin
            cyc(8);
        end
        bus.ps2_clk = 1'b0;
        cyc(HALF - 8);
        if (glitch) begin
            bus.ps2_clk = 1'b1;
            cyc(1);
            bus.ps2_clk = 1'b0;
            cyc(7);
        end else begin
            cyc(8);
        end
        bus.ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of the frame; a full frame is followed by an idle gap
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic glitch, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
        if (nbits == 11) cyc(2 * HALF);
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input logic glitch);
        foreach (seq[i]) send_frame(seq[i], 1'b0, glitch, 11);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset_n      = 1'b0;
        cyc(5);
        chk("rst_key", 32'(bus.ps2_key), 32'h000);
        chk("rst_err", 32'(bus.frame_err), 32'h0);
        reset_n = 1'b1;
        cyc(5);

        // 0x1C make, with latency check on the stop-bit edge
        send_frame(8'h1C, 1'b0, 1'b0, 10);
        bus.ps2_data = 1'b1;
        cyc(HALF);
        bus.ps2_clk = 1'b0;
        cyc(FILT + 1);
        chk("lat_before", 32'(bus.ps2_key), 32'h000);
        cyc(1);
        chk("lat_after", 32'(bus.ps2_key), 32'h61C);
        cyc(HALF - FILT - 2);
        bus.ps2_clk = 1'b1;
        cyc(2 * HALF);
        chk("t1_ev", 32'(ev_cnt), 32'd1);
        chk("t1_err", 32'(err_cyc), 32'd0);

        // E0 F0 75: extended break
        send_frame(8'hE0, 1'b0, 1'b0, 11);
        chk("t2_e0_ev", 32'(ev_cnt), 32'd1);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        chk("t2_f0_ev", 32'(ev_cnt), 32'd1);
        send_frame(8'h75, 1'b0, 1'b0, 11);
        chk("t2_ev", 32'(ev_cnt), 32'd2);
        chk("t2_key", 32'(bus.ps2_key), 32'h175);

        // bad parity on 0x29, then F0 29
        send_frame(8'h29, 1'b1, 1'b0, 11);
        chk("t3_err", 32'(err_cyc), 32'd1);
        chk("t3_key", 32'(bus.ps2_key), 32'h175);
        chk("t3_ev", 32'(ev_cnt), 32'd2);
        send_seq('{8'hF0, 8'h29}, 1'b0);
        chk("t3b_key", 32'(bus.ps2_key), 32'h429);
        chk("t3b_ev", 32'(ev_cnt), 32'd3);

        // partial frame abandoned by timeout, then 0x16
        send_frame(8'h55, 1'b0, 1'b0, 5);
        cyc(TO + 20);
        send_frame(8'h16, 1'b0, 1'b0, 11);
        chk("t4_key", 32'(bus.ps2_key), 32'h216);
        chk("t4_ev", 32'(ev_cnt), 32'd4);
        chk("t4_err", 32'(err_cyc), 32'd1);

        // Pause sequence: no events
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1'b0);
        chk("t5_ev", 32'(ev_cnt), 32'd4);
        chk("t5_key", 32'(bus.ps2_key), 32'h216);

        // glitched clock, repeated make then break
        send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 1'b1);
        chk("t6_ev", 32'(ev_cnt), 32'(4 + TM_EV));
        chk("t6_key", 32'(bus.ps2_key), 32'h01C);
        chk("t6_err", 32'(err_cyc), 32'd1);

        // reset mid-frame; next frame needs its own start bit
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        reset_n = 1'b0;
        cyc(3);
        chk("t7_rst_key", 32'(bus.ps2_key), 32'h000);
        chk("t7_rst_err", 32'(bus.frame_err), 32'h0);
        reset_n = 1'b1;
        cyc(5);
        send_frame(8'h5A, 1'b0, 1'b0, 11);
        chk("t7_key", 32'(bus.ps2_key), 32'h65A);
        chk("t7_ev", 32'(ev_cnt), 32'(5 + TM_EV));
        chk("t7_err", 32'(err_cyc), 32'd1);
        chk("stray", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILT_CYC, default 8: clk_sys cycles ps2_clk must hold a new level before it is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 50000: clk_sys cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 clk_sys  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-007 ps2_key  output  11  key event word: [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-008 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer.
REQ-010 The filtered clock SHALL change only after the synchronized ps2_clk holds the new level for FILT_CYC consecutive cycles.
REQ-011 A filtered 1->0 transition SHALL sample synchronized ps2_data in that same cycle (the "edge cycle").
REQ-012 The frame SHALL be 11 bits: start=0, D0..D7 LSB first, odd parity, stop=1.
REQ-013 The frame FSM SHALL use the states IDLE, DATA, PARITY and STOP.
- IDLE->DATA on a sampled 0.
- A sampled 1 in IDLE SHALL be ignored.
REQ-014 If no edge cycle occurs for TIMEOUT_CYC cycles in DATA/PARITY/STOP, the FSM SHALL return to IDLE, discard the partial frame and keep prefix state.
REQ-015 A parity error or stop=0 SHALL drop the byte, clear both prefix flags and pulse frame_err in the edge cycle+1; ps2_key SHALL remain unchanged.
REQ-016 Byte rules for an accepted byte:
- 0xE0 sets ext.
- 0xF0 sets brk.
- 0xE1 sets a skip counter to 7; the next 7 bytes are discarded with no event.
- 0xAA, 0xFA, 0xEE and 0xFE received with no prefix set are ignored.
- Any other byte is a code byte.
REQ-017 A code byte SHALL update ps2_key in the edge cycle+1 to {~ps2_key[10], ~brk, ext, byte}, then clear ext and brk.
REQ-018 ps2_key[10] SHALL toggle exactly once per emitted event; bits [9:0] SHALL be stable between events.
REQ-019 Prefix order F0 then E0 SHALL be accepted the same as E0 then F0.
REQ-020 A repeated prefix SHALL be idempotent.

Reset
REQ-021 While reset_n=0 the block SHALL set ps2_key=11'h000, frame_err=0, FSM=IDLE, ext=brk=0, skip counter=0, filter counters=0, filtered clock=1, and clear the typematic register.
REQ-022 Reset asserted mid-frame SHALL discard the frame; the first frame after release SHALL need a fresh start bit.

Configuration
REQ-023 With PS2_TYPEMATIC_FILTER_EN defined, the block SHALL keep the last {ext,code} made and not yet broken.
- A make code equal to it SHALL produce no event.
- A break of it SHALL clear the register and emit an event.
REQ-024 Without PS2_TYPEMATIC_FILTER_EN, every make code SHALL emit an event and the register SHALL NOT exist.

Structure
REQ-025 Package ps2_pkg SHALL hold:
- The constants PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1, RSP_BAT=8'hAA, RSP_ACK=8'hFA, RSP_ECHO=8'hEE and RSP_RESEND=8'hFE.
- The frame-state enum.
- A ps2_key field-index localparam set.
REQ-026 Sub-module ps2_rx_frame SHALL contain the synchronizers, filter, frame FSM and timeout.
- It SHALL output a byte with a one-cycle valid strobe and a one-cycle error strobe.
- ps2_key_decoder SHALL hold the prefix/skip/typematic logic.

Verification
REQ-027 Frame 0x1C with correct parity: ps2_key=11'h61C, [10] flips 0->1, one cycle after the stop edge.
REQ-028 Bytes E0,F0,75: exactly one event, ps2_key[9:0]=10'h175; the E0 and F0 bytes alone cause no event.
REQ-029 Bad parity on 0x29: frame_err pulses 1 cycle, ps2_key unchanged; a following F0,29 gives [9:0]=10'h029.
REQ-030 ps2_clk stops after 4 data bits for TIMEOUT_CYC+1 cycles, then full frame 0x16: one event with code 0x16, no frame_err.
REQ-031 Bytes E1,14,77,E1,F0,14,F0,77: zero events.
REQ-032 1-cycle glitches on ps2_clk (< FILT_CYC) between bits: no sampling change; with PS2_TYPEMATIC_FILTER_EN, 1C,1C,1C,F0,1C gives exactly 2 events.
